// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling ratio, default frame parameters.
// Optional parity support is enabled by defining UART_TX_PARITY_EN.
package uart_tx_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;
  localparam int DEF_DVSR    = 163;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Width of a 0..modulus-1 counter, never narrower than one bit.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// FIFO-side handshake between a first-word-fall-through TX FIFO and uart_tx.
// iPODD only exists when UART_TX_PARITY_EN is defined.
interface uart_tx_if #(parameter int DBIT = 8);

  logic            iEMPTY;
  logic [DBIT-1:0] iD;
  logic            oDEQ;
`ifdef UART_TX_PARITY_EN
  logic            iPODD;

  modport master (output iEMPTY, output iD, output iPODD, input oDEQ);
  modport slave  (input iEMPTY, input iD, input iPODD, output oDEQ);
`else
  modport master (output iEMPTY, output iD, input oDEQ);
  modport slave  (input iEMPTY, input iD, output oDEQ);
`endif

endinterface

// File: rtl/uart_tx_baud_gen.sv
// Mod-DVSR oversampling tick divider with synchronous clear; shared by the UART transmitter and receiver.
module baud_gen
  import uart_tx_pkg::*;
#(
  parameter int DVSR = DEF_DVSR
) (
  input  logic iCLK,
  input  logic iRESET,
  input  logic iCLR,
  output logic oTICK
);

  localparam int            CW   = cnt_width(DVSR);
  localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (iCLR || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oTICK = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a FWFT FIFO: start bit, DBIT data bits LSB-first, optional parity, stop.
// Define UART_TX_PARITY_EN to insert a parity bit (even parity XOR iPODD) after the data bits.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK,
  parameter int DVSR    = DEF_DVSR
) (
  input  logic        iCLK,
  input  logic        iRESET,
  uart_tx_if.slave    fifo,
  output logic        oTX,
  output logic        oBUSY
);

  localparam int            NW      = $clog2(DBIT) + 1;
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
  localparam logic [4:0]    S_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    SB_LAST = 5'(SB_TICK - 1);

  uart_state_e     state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic tick;
  logic baud_clr;
  logic deq;

  baud_gen #(.DVSR(DVSR)) u_baud (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .iCLR   (baud_clr),
    .oTICK  (tick)
  );

  // Word is taken on the same edge the strobe is seen by the FIFO; held off during reset.
  assign deq       = (state_q == IDLE) && !fifo.iEMPTY && !iRESET;
  assign fifo.oDEQ = deq;

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    n_d      = n_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    baud_clr = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (deq) begin
          shreg_d  = fifo.iD;
          state_d  = START;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          s_d      = '0;
          n_d      = '0;
          baud_clr = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = (^fifo.iD) ^ fifo.iPODD;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            state_d = DATA;
            tx_d    = shreg_q[0];
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
              tx_d    = parity_q;
`else
              state_d = STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              n_d     = n_q + 1'b1;
              shreg_d = shreg_q >> 1;
              tx_d    = shreg_d[0];
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_q == SB_LAST) begin
            s_d     = '0;
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q  <= IDLE;
      s_q      <= '0;
      n_q      <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      n_q      <= n_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign oTX   = tx_q;
  assign oBUSY = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx (DVSR=4, DBIT=8: 64-clock bits); second instance covers SB_TICK=32.
// Parity frames are exercised when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if #(.DBIT(8)) if0 ();
  uart_tx_if #(.DBIT(8)) if1 ();
  logic tx0, busy0, tx1, busy1;

  uart_tx #(.DBIT(8), .SB_TICK(16), .DVSR(4)) dut (
    .iCLK(clk), .iRESET(rst), .fifo(if0), .oTX(tx0), .oBUSY(busy0)
  );
  uart_tx #(.DBIT(8), .SB_TICK(32), .DVSR(4)) dut32 (
    .iCLK(clk), .iRESET(rst), .fifo(if1), .oTX(tx1), .oBUSY(busy1)
  );

  // FWFT FIFO models, 16 deep
  logic [7:0] fmem0 [16];
  logic [7:0] fmem1 [16];
  logic [4:0] wr0 = '0, wr1 = '0;
  logic [4:0] rd0 = '0, rd1 = '0;
  int ndeq0 = 0;

  assign if0.iEMPTY = (rd0 == wr0);
  assign if0.iD     = fmem0[rd0[3:0]];
  assign if1.iEMPTY = (rd1 == wr1);
  assign if1.iD     = fmem1[rd1[3:0]];

  always @(posedge clk) begin
    if (if0.oDEQ) begin
      rd0   <= rd0 + 5'd1;
      ndeq0 <= ndeq0 + 1;
    end
    if (if1.oDEQ) rd1 <= rd1 + 5'd1;
  end

`ifdef UART_TX_PARITY_EN
  logic podd = 1'b0;
  assign if0.iPODD = podd;
  assign if1.iPODD = podd;
  localparam int NSLOTS = 11;
`else
  localparam int NSLOTS = 10;
`endif

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // slot i = line level during bit period i (start, d0..d7, stop)
    logic       par;   // even parity of data
  } vec_t;

  vec_t vecs [6];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input bit ok, input string what);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s", what);
    end
  endtask

  task automatic push(input bit sel, input logic [7:0] v);
    if (sel) begin
      fmem1[wr1[3:0]] = v;
      wr1 = wr1 + 5'd1;
    end else begin
      fmem0[wr0[3:0]] = v;
      wr0 = wr0 + 5'd1;
    end
    #1;
  endtask

  function automatic logic [10:0] mk_exp(input vec_t v);
`ifdef UART_TX_PARITY_EN
    return {1'b1, v.par, v.line[8:0]};
`else
    return {1'b0, v.line};
`endif
  endfunction

  // Waits for the strobe, then checks every clock of every bit slot and the idle clock after STOP.
  task automatic run_frame(input bit sel, input logic [7:0] data, input logic [10:0] exp,
                           input int nslots, input int stop_clks, input bit expect_next);
    int   waited = 0;
    int   len, bad_line, bad_busy, bad_deq;
    logic ln;
    while (!(sel ? if1.oDEQ : if0.oDEQ) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check((sel ? if1.oDEQ : if0.oDEQ) === 1'b1,
          $sformatf("deq_wait %02h: oDEQ=0 after %0d clocks, required 1", data, waited));
    if ((sel ? if1.oDEQ : if0.oDEQ) !== 1'b1) return;
    check((sel ? busy1 : busy0) === 1'b0,
          $sformatf("busy_pre %02h: oBUSY=%b at strobe, required 0", data, sel ? busy1 : busy0));
    bad_busy = 0;
    bad_deq  = 0;
    for (int slot = 0; slot < nslots; slot++) begin
      len      = (slot == nslots - 1) ? stop_clks : 64;
      bad_line = 0;
      ln       = 1'b0;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if ((sel ? tx1 : tx0) !== exp[slot]) begin
          bad_line++;
          ln = sel ? tx1 : tx0;
        end
        if ((sel ? busy1 : busy0) !== 1'b1) bad_busy++;
        if ((sel ? if1.oDEQ : if0.oDEQ) !== 1'b0) bad_deq++;
      end
      check(bad_line == 0, $sformatf("line %02h slot %0d: %0d of %0d clocks showed %b, required %b",
                                     data, slot, bad_line, len, ln, exp[slot]));
    end
    check(bad_busy == 0 && bad_deq == 0,
          $sformatf("busy_deq %02h: %0d clocks busy low, %0d clocks deq high, required 0 and 0",
                    data, bad_busy, bad_deq));
    @(negedge clk);
    check((sel ? tx1 : tx0) === 1'b1 && (sel ? busy1 : busy0) === 1'b0 &&
          (sel ? if1.oDEQ : if0.oDEQ) === expect_next,
          $sformatf("idle_gap %02h: tx=%b busy=%b deq=%b, required 1 0 %b", data,
                    sel ? tx1 : tx0, sel ? busy1 : busy0, sel ? if1.oDEQ : if0.oDEQ, expect_next));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int base;
    int waited;
    vec_t pv;

    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[3] = '{8'h3C, 10'b1001111000, 1'b0};
    vecs[4] = '{8'h55, 10'b1010101010, 1'b0};
    vecs[5] = '{8'h81, 10'b1100000010, 1'b0};

    // Reset state, then a long idle with the FIFO empty
    repeat (3) @(negedge clk);
    check(tx0 === 1'b1 && busy0 === 1'b0 && if0.oDEQ === 1'b0,
          $sformatf("reset_state: tx=%b busy=%b deq=%b, required 1 0 0", tx0, busy0, if0.oDEQ));
    check(tx1 === 1'b1 && busy1 === 1'b0 && if1.oDEQ === 1'b0,
          $sformatf("reset_state32: tx=%b busy=%b deq=%b, required 1 0 0", tx1, busy1, if1.oDEQ));
    rst = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || if0.oDEQ !== 1'b0 ||
          tx1 !== 1'b1 || busy1 !== 1'b0 || if1.oDEQ !== 1'b0) bad++;
    end
    check(bad == 0, $sformatf("idle_empty: %0d bad clocks of 1000, required 0", bad));

    // Single 0xA5 frame
    push(1'b0, vecs[0].data);
    run_frame(1'b0, vecs[0].data, mk_exp(vecs[0]), NSLOTS, 64, 1'b0);

    // Three back-to-back frames
    base = ndeq0;
    for (int i = 1; i <= 3; i++) push(1'b0, vecs[i].data);
    for (int i = 1; i <= 3; i++) begin
      run_frame(1'b0, vecs[i].data, mk_exp(vecs[i]), NSLOTS, 64, i < 3);
    end
    check(ndeq0 - base == 3, $sformatf("deq_count: %0d strobes, required 3", ndeq0 - base));
    check(if0.iEMPTY === 1'b1, $sformatf("fifo_empty: iEMPTY=%b, required 1", if0.iEMPTY));

    // Reset 200 clocks into a 0x55 frame
    push(1'b0, vecs[4].data);
    waited = 0;
    while (if0.oDEQ !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check(if0.oDEQ === 1'b1, $sformatf("deq_wait 55: oDEQ=%b, required 1", if0.oDEQ));
    repeat (200) @(negedge clk);
    check(busy0 === 1'b1, $sformatf("busy_mid 55: oBUSY=%b, required 1", busy0));
    #1 rst = 1'b1;
    #1;
    check(tx0 === 1'b1 && busy0 === 1'b0,
          $sformatf("async_reset: tx=%b busy=%b before next edge, required 1 0", tx0, busy0));
    base = ndeq0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || if0.oDEQ !== 1'b0) bad++;
    end
    check(bad == 0, $sformatf("post_reset_idle: %0d bad clocks of 1000, required 0", bad));
    check(ndeq0 == base, $sformatf("no_resend: %0d strobes after reset, required 0", ndeq0 - base));

    // Two stop bits on the SB_TICK=32 instance
    push(1'b1, vecs[5].data);
    run_frame(1'b1, vecs[5].data, mk_exp(vecs[5]), NSLOTS, 128, 1'b0);

`ifdef UART_TX_PARITY_EN
    // 0x07: three ones, even parity 1; odd select flips it
    pv = '{8'h07, 10'b1000001110, 1'b1};
    podd = 1'b0;
    push(1'b0, pv.data);
    run_frame(1'b0, pv.data, {1'b1, 1'b1, pv.line[8:0]}, 11, 64, 1'b0);
    podd = 1'b1;
    push(1'b0, pv.data);
    run_frame(1'b0, pv.data, {1'b1, 1'b0, pv.line[8:0]}, 11, 64, 1'b0);
    podd = 1'b0;
`else
    pv = vecs[0];
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
